// File: rtl/data_axi_responder.sv
// Responder end of the data-cache interface: turns each accepted call into one
// single-beat AXI4 read or write and answers with a one-cycle return_ready pulse.
module data_axi_responder #(
    parameter logic [3:0] AXI_ID = 4'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_interface_enable,
    input  logic        write_enable,
    input  logic [2:0]  read_size,
    input  logic [2:0]  write_size,
    input  logic [31:0] data_interface_raddr,
    input  logic [31:0] data_interface_waddr,
    input  logic [31:0] data_interface_wdata,
    input  logic        data_interface_call_begin,
    output logic        data_interface_return_ready,
    output logic [31:0] data_interface_rdata,
    output logic        busy,
    output logic        bus_error,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        bus_error_q, bus_error_d;
    logic [3:0]  strb;

    // IDs are never checked: only one transaction can be in flight.
    logic unused_ok;
    assign unused_ok = ^{rid, rlast, bid, read_size[2]};

    always_comb begin
        case (write_size)
            3'd0:    strb = 4'b0001 << data_interface_waddr[1:0];
            3'd1:    strb = 4'b0011 << data_interface_waddr[1:0];
            default: strb = 4'hF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bus_error_d = bus_error_q;

        arvalid                     = 1'b0;
        rready                      = 1'b0;
        awvalid                     = 1'b0;
        wvalid                      = 1'b0;
        bready                      = 1'b0;
        data_interface_return_ready = 1'b0;
        data_interface_rdata        = '0;

        case (state_q)
            S_IDLE: begin
                if (data_interface_call_begin && data_interface_enable) begin
                    we_d      = write_enable;
                    size_d    = write_enable ? write_size[1:0] : read_size[1:0];
                    addr_d    = write_enable ? data_interface_waddr : data_interface_raddr;
                    wdata_d   = data_interface_wdata;
                    wstrb_d   = write_enable ? strb : '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = write_enable ? S_AW_W : S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata;
                    if (rresp != 2'b00) bus_error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_AW_W: begin
                // Each channel drops its valid after its own handshake.
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q || awready;
                w_done_d  = w_done_q || wready;
                if (aw_done_d && w_done_d) state_d = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    if (bresp != 2'b00) bus_error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                data_interface_return_ready = 1'b1;
                data_interface_rdata        = we_q ? '0 : rdata_q;
                state_d                     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign bus_error = bus_error_q;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'h00;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'h00;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = wvalid;

endmodule

// File: tb/tb_data_axi_responder.sv
// Bench for data_axi_responder: the bench plays cache and AXI slave, checking
// handshakes, strobes, latency and error stickiness against a behavioural model.
`timescale 1ns/1ps
module tb_data_axi_responder;

    logic        clk, reset;
    logic        data_interface_enable, write_enable;
    logic [2:0]  read_size, write_size;
    logic [31:0] data_interface_raddr, data_interface_waddr, data_interface_wdata;
    logic        data_interface_call_begin, data_interface_return_ready;
    logic [31:0] data_interface_rdata;
    logic        busy, bus_error;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int   errors = 0;
    int   checks = 0;
    logic err_model;
    int   ar_hs_cnt = 0;
    int   ret_cnt = 0;

    data_axi_responder #(.AXI_ID(4'h1)) dut (
        .clk(clk), .reset(reset),
        .data_interface_enable(data_interface_enable), .write_enable(write_enable),
        .read_size(read_size), .write_size(write_size),
        .data_interface_raddr(data_interface_raddr), .data_interface_waddr(data_interface_waddr),
        .data_interface_wdata(data_interface_wdata),
        .data_interface_call_begin(data_interface_call_begin),
        .data_interface_return_ready(data_interface_return_ready),
        .data_interface_rdata(data_interface_rdata), .busy(busy), .bus_error(bus_error),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Count AR handshakes and completions just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (arvalid && arready) ar_hs_cnt++;
            if (data_interface_return_ready) ret_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        data_interface_call_begin = 0;
    endtask

    function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [31:0] addr);
        int s;
        int a;
        a = int'(addr % 4);
        if (size == 0)      s = (1 << a) % 16;
        else if (size == 1) s = (3 << a) % 16;
        else                s = 15;
        return 4'(s);
    endfunction

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                           input logic [1:0] resp, input int ar_stall, input int r_stall,
                           input bit extra_pulse);
        time t0;
        int  n;
        int  lat;
        t0 = $time;
        write_enable = 0; read_size = size; data_interface_raddr = addr;
        data_interface_waddr = $urandom; write_size = 3'($urandom); data_interface_wdata = $urandom;
        data_interface_enable = 1; data_interface_call_begin = 1;
        tick();
        data_interface_raddr = $urandom; read_size = 3'($urandom);
        if (extra_pulse) begin
            data_interface_call_begin = 1; data_interface_enable = 1; write_enable = 1;
        end
        n = 0;
        while (!arvalid && n < 20) begin tick(); n++; end
        checks++;
        if (arvalid !== 1'b1) begin
            errors++; $display("FAIL ar_valid_timeout: arvalid=%b required 1", arvalid);
        end else begin
            checks++;
            if ({araddr, arsize, arid, arlen, arburst} !== {addr, 1'b0, size[1:0], 4'h1, 8'h00, 2'b01}) begin
                errors++;
                $display("FAIL ar_fields: addr=%h size=%0d id=%h len=%h burst=%b required addr=%h size=%0d id=1 len=0 burst=01",
                         araddr, arsize, arid, arlen, arburst, addr, size[1:0]);
            end
            for (int i = 0; i < ar_stall; i++) begin
                tick();
                checks++;
                if (arvalid !== 1'b1 || araddr !== addr) begin
                    errors++; $display("FAIL ar_hold: arvalid=%b araddr=%h required 1 %h", arvalid, araddr, addr);
                end
            end
            arready = 1; tick(); arready = 0;
            n = 0;
            while (!rready && n < 20) begin tick(); n++; end
            checks++;
            if (rready !== 1'b1 || arvalid !== 1'b0) begin
                errors++; $display("FAIL r_phase: rready=%b arvalid=%b required 1 0", rready, arvalid);
            end
            for (int i = 0; i < r_stall; i++) tick();
            rvalid = 1; rdata = data; rresp = resp;
            tick();
            rvalid = 0; rdata = $urandom; rresp = 2'($urandom);
        end
        n = 0;
        while (!data_interface_return_ready && n < 20) begin tick(); n++; end
        lat = int'(($time - t0) / 10);
        checks++;
        if (data_interface_return_ready !== 1'b1) begin
            errors++; $display("FAIL read_return_timeout: return_ready=%b required 1", data_interface_return_ready);
        end else begin
            checks++;
            if (lat != 3 + ar_stall + r_stall || data_interface_rdata !== data) begin
                errors++;
                $display("FAIL read_return: latency=%0d rdata=%h required latency=%0d rdata=%h",
                         lat, data_interface_rdata, 3 + ar_stall + r_stall, data);
            end
        end
        if (resp != 2'b00) err_model = 1;
        checks++;
        if (bus_error !== err_model) begin
            errors++; $display("FAIL read_bus_error: got %b required %b", bus_error, err_model);
        end
        tick();
        checks++;
        if (data_interface_return_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL read_end: return_ready=%b busy=%b required 0 0", data_interface_return_ready, busy);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                            input logic [1:0] resp, input int aw_stall, input int w_stall, input int b_stall);
        time t0;
        int  n;
        int  lat;
        int  mx;
        logic [3:0] exp_strb;
        exp_strb = model_strb(size, addr);
        mx = (aw_stall > w_stall) ? aw_stall : w_stall;
        t0 = $time;
        write_enable = 1; write_size = size; data_interface_waddr = addr; data_interface_wdata = data;
        data_interface_raddr = $urandom; read_size = 3'($urandom);
        data_interface_enable = 1; data_interface_call_begin = 1;
        tick();
        data_interface_waddr = $urandom; data_interface_wdata = $urandom; write_size = 3'($urandom);
        write_enable = 1'($urandom);
        fork
            begin
                int na;
                na = 0;
                while (!awvalid && na < 20) begin @(negedge clk); na++; end
                checks++;
                if (awvalid !== 1'b1) begin
                    errors++; $display("FAIL aw_valid_timeout: awvalid=%b required 1", awvalid);
                end else begin
                    checks++;
                    if ({awaddr, awsize, awid, awlen, awburst} !== {addr, 1'b0, size[1:0], 4'h1, 8'h00, 2'b01}) begin
                        errors++;
                        $display("FAIL aw_fields: addr=%h size=%0d id=%h len=%h burst=%b required addr=%h size=%0d id=1 len=0 burst=01",
                                 awaddr, awsize, awid, awlen, awburst, addr, size[1:0]);
                    end
                    for (int i = 0; i < aw_stall; i++) begin
                        @(negedge clk);
                        checks++;
                        if (awvalid !== 1'b1 || awaddr !== addr) begin
                            errors++; $display("FAIL aw_hold: awvalid=%b awaddr=%h required 1 %h", awvalid, awaddr, addr);
                        end
                    end
                    awready = 1; @(negedge clk); awready = 0;
                    checks++;
                    if (awvalid !== 1'b0) begin
                        errors++; $display("FAIL aw_drop: awvalid=%b required 0", awvalid);
                    end
                end
            end
            begin
                int nw;
                nw = 0;
                while (!wvalid && nw < 20) begin @(negedge clk); nw++; end
                checks++;
                if (wvalid !== 1'b1) begin
                    errors++; $display("FAIL w_valid_timeout: wvalid=%b required 1", wvalid);
                end else begin
                    checks++;
                    if ({wdata, wstrb, wlast} !== {data, exp_strb, 1'b1}) begin
                        errors++;
                        $display("FAIL w_fields: wdata=%h wstrb=%b wlast=%b required %h %b 1", wdata, wstrb, wlast, data, exp_strb);
                    end
                    for (int i = 0; i < w_stall; i++) begin
                        @(negedge clk);
                        checks++;
                        if (wvalid !== 1'b1 || wdata !== data || wstrb !== exp_strb) begin
                            errors++; $display("FAIL w_hold: wvalid=%b wdata=%h wstrb=%b required 1 %h %b", wvalid, wdata, wstrb, data, exp_strb);
                        end
                    end
                    wready = 1; @(negedge clk); wready = 0;
                    checks++;
                    if (wvalid !== 1'b0) begin
                        errors++; $display("FAIL w_drop: wvalid=%b required 0", wvalid);
                    end
                end
            end
        join
        n = 0;
        while (!bready && n < 20) begin tick(); n++; end
        checks++;
        if (bready !== 1'b1) begin
            errors++; $display("FAIL b_timeout: bready=%b required 1", bready);
        end else begin
            for (int i = 0; i < b_stall; i++) tick();
            bvalid = 1; bresp = resp;
            tick();
            bvalid = 0; bresp = 2'($urandom);
        end
        n = 0;
        while (!data_interface_return_ready && n < 20) begin tick(); n++; end
        lat = int'(($time - t0) / 10);
        checks++;
        if (data_interface_return_ready !== 1'b1) begin
            errors++; $display("FAIL write_return_timeout: return_ready=%b required 1", data_interface_return_ready);
        end else begin
            checks++;
            if (lat != 3 + mx + b_stall || data_interface_rdata !== 32'h0) begin
                errors++;
                $display("FAIL write_return: latency=%0d rdata=%h required latency=%0d rdata=0",
                         lat, data_interface_rdata, 3 + mx + b_stall);
            end
        end
        if (resp != 2'b00) err_model = 1;
        checks++;
        if (bus_error !== err_model) begin
            errors++; $display("FAIL write_bus_error: got %b required %b", bus_error, err_model);
        end
        tick();
        checks++;
        if (data_interface_return_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL write_end: return_ready=%b busy=%b required 0 0", data_interface_return_ready, busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({data_interface_return_ready, data_interface_rdata, busy, bus_error, arvalid, rready,
             awvalid, wvalid, wlast, bready} !== '0) begin
            errors++; $display("FAIL reset_ctrl: rr=%b rdata=%h busy=%b err=%b arv=%b rr=%b awv=%b wv=%b wl=%b br=%b required all 0",
                               data_interface_return_ready, data_interface_rdata, busy, bus_error, arvalid, rready,
                               awvalid, wvalid, wlast, bready);
        end
        checks++;
        if ({araddr, awaddr, wdata, wstrb, arsize, awsize} !== '0) begin
            errors++; $display("FAIL reset_data: araddr=%h awaddr=%h wdata=%h wstrb=%b arsize=%0d awsize=%0d required 0",
                               araddr, awaddr, wdata, wstrb, arsize, awsize);
        end
        checks++;
        if ({arid, awid, arlen, awlen, arburst, awburst} !== {4'h1, 4'h1, 8'h00, 8'h00, 2'b01, 2'b01}) begin
            errors++; $display("FAIL reset_fixed: arid=%h awid=%h arlen=%h awlen=%h arburst=%b awburst=%b required 1 1 0 0 01 01",
                               arid, awid, arlen, awlen, arburst, awburst);
        end
        reset = 1;
        tick();
        data_interface_enable = 0; data_interface_call_begin = 1; write_enable = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || arvalid !== 1'b0) begin
            errors++; $display("FAIL disabled_call: busy=%b arvalid=%b required 0 0", busy, arvalid);
        end
    endtask

    task automatic test_read_word();
        do_read(32'h1FC0_0010, 3'd2, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    endtask

    task automatic test_write_byte_stall();
        do_write(32'h0000_0103, 3'd0, 32'h1100_0000, 2'b00, 4, 0, 0);
    endtask

    task automatic test_write_sizes();
        do_write(32'h0000_0002, 3'd1, 32'hABCD_0000, 2'b00, 0, 0, 0);
        do_write(32'h0000_0040, 3'd2, 32'h1234_5678, 2'b00, 0, 0, 1);
        do_write(32'h0000_0003, 3'd1, 32'h5500_0000, 2'b00, 0, 2, 0);
        do_write(32'h0000_0001, 3'd5, 32'h0BAD_F00D, 2'b00, 1, 1, 0);
    endtask

    task automatic test_ignored_call();
        int a0;
        int r0;
        a0 = ar_hs_cnt; r0 = ret_cnt;
        do_read(32'h0000_2000, 3'd2, 32'hCAFE_F00D, 2'b00, 3, 1, 1);
        repeat (3) tick();
        checks++;
        if (ar_hs_cnt - a0 != 1 || ret_cnt - r0 != 1) begin
            errors++; $display("FAIL ignored_call: ar=%0d returns=%0d required 1 1", ar_hs_cnt - a0, ret_cnt - r0);
        end
    endtask

    task automatic test_bus_error();
        do_read(32'h0000_3000, 3'd2, 32'h0000_0BAD, 2'b10, 0, 0, 0);
        do_read(32'h0000_3004, 3'd2, 32'h600D_600D, 2'b00, 1, 0, 0);
        do_write(32'h0000_3008, 3'd2, 32'h7777_7777, 2'b00, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int n;
        write_enable = 0; read_size = 3'd2; data_interface_raddr = 32'h0000_4000;
        data_interface_enable = 1; data_interface_call_begin = 1;
        tick();
        arready = 1; tick(); arready = 0;
        n = 0;
        while (!rready && n < 20) begin tick(); n++; end
        checks++;
        if (rready !== 1'b1) begin
            errors++; $display("FAIL mid_reach_r: rready=%b required 1", rready);
        end
        #2 reset = 0;
        err_model = 0;
        #1;
        checks++;
        if ({rready, arvalid, busy, bus_error} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset: rready=%b arvalid=%b busy=%b bus_error=%b required 0 0 0 0",
                               rready, arvalid, busy, bus_error);
        end
        tick();
        reset = 1;
        tick();
        do_read(32'h0000_4010, 3'd0, 32'h89AB_CDEF, 2'b00, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = ret_cnt;
        do_write(32'h0000_5000, 3'd2, 32'hA5A5_A5A5, 2'b00, 0, 0, 0);
        do_read(32'h0000_5000, 3'd2, 32'h5A5A_5A5A, 2'b00, 0, 0, 0);
        do_write(32'h0000_5002, 3'd0, 32'h00FF_0000, 2'b00, 0, 0, 0);
        checks++;
        if (ret_cnt - r0 != 3) begin
            errors++; $display("FAIL back_to_back: returns=%0d required 3", ret_cnt - r0);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp;
        for (int i = 0; i < 40; i++) begin
            resp = ($urandom % 8 == 0) ? 2'($urandom) : 2'b00;
            if ($urandom % 2 == 0)
                do_read($urandom, 3'($urandom % 3), $urandom, resp,
                        int'($urandom % 4), int'($urandom % 4), 0);
            else
                do_write($urandom, 3'($urandom % 8), $urandom, resp,
                         int'($urandom % 4), int'($urandom % 4), int'($urandom % 3));
        end
    endtask

    initial begin
        reset = 0; err_model = 0;
        data_interface_enable = 0; write_enable = 0; read_size = 0; write_size = 0;
        data_interface_raddr = 0; data_interface_waddr = 0; data_interface_wdata = 0;
        data_interface_call_begin = 0;
        arready = 0; awready = 0; wready = 0;
        rid = 4'h1; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        bid = 4'h1; bresp = 0; bvalid = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_read_word();
        test_write_byte_stall();
        test_write_sizes();
        test_ignored_call();
        test_bus_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
